// File: rtl/ysyx_22050854_idu_stage.sv
// Instruction-decode stage: combinational RV32I/RV64I decoder feeding a 2-entry
// skid FIFO, so in_ready never depends combinationally on out_ready.
module ysyx_22050854_idu_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      ext_op,
    output logic            reg_wr,
    output logic [2:0]      branch,
    output logic            mem_to_reg,
    output logic            mem_wr,
    output logic [2:0]      mem_op,
    output logic            alu_src1,
    output logic [1:0]      alu_src2,
    output logic [3:0]      alu_ctr,
    output logic            is_word,
    output logic            illegal,
    output logic            ebreak,
    output logic            halted
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] EXT_I = 3'b000, EXT_U = 3'b001, EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011, EXT_J = 3'b100, EXT_NONE = 3'b111;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      ext_op;
        logic            reg_wr;
        logic [2:0]      branch;
        logic            mem_to_reg;
        logic            mem_wr;
        logic [2:0]      mem_op;
        logic            alu_src1;
        logic [1:0]      alu_src2;
        logic [3:0]      alu_ctr;
        logic            is_word;
        logic            illegal;
        logic            ebreak;
    } dec_t;

    // funct3 maps straight onto alu_ctr[2:0]; alt selects sub/sra; sltu is the odd one out
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        if (f3 == 3'b011) return 4'b1010;
        return {alt, f3};
    endfunction

    logic [31:0]        instr;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [31:0] imm_w;
    dec_t               dec_p0;

    // Gate the raw word so an undriven bus cannot reach the decoder while idle
    assign instr = in_valid ? in_instr : 32'h0;
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];

    always_comb begin
        dec_p0        = '0;
        dec_p0.rs1    = instr[19:15];
        dec_p0.rs2    = instr[24:20];
        dec_p0.rd     = instr[11:7];
        dec_p0.ext_op = EXT_NONE;
        dec_p0.mem_op = 3'b111;
        imm_w         = '0;
        case (opc)
            OPC_LUI: begin
                dec_p0.ext_op   = EXT_U;
                dec_p0.alu_ctr  = 4'b0011;
                dec_p0.alu_src2 = 2'b01;
                dec_p0.reg_wr   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_p0.ext_op   = EXT_U;
                dec_p0.alu_src1 = 1'b1;
                dec_p0.alu_src2 = 2'b01;
                dec_p0.reg_wr   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec_p0.ext_op   = (opc == OPC_JAL) ? EXT_J : EXT_I;
                dec_p0.branch   = (opc == OPC_JAL) ? 3'b001 : 3'b010;
                dec_p0.alu_src1 = 1'b1;
                dec_p0.alu_src2 = 2'b10;
                dec_p0.reg_wr   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_p0.ext_op  = EXT_B;
                dec_p0.alu_ctr = f3[1] ? 4'b1010 : 4'b0010;
                case (f3)
                    3'b000:         dec_p0.branch = 3'b100;
                    3'b001:         dec_p0.branch = 3'b101;
                    3'b100, 3'b110: dec_p0.branch = 3'b110;
                    3'b101, 3'b111: dec_p0.branch = 3'b111;
                    default:        dec_p0.branch = 3'b000;
                endcase
            end
            OPC_LOAD: begin
                dec_p0.ext_op     = EXT_I;
                dec_p0.alu_src2   = 2'b01;
                dec_p0.mem_to_reg = 1'b1;
                dec_p0.mem_op     = f3;
                dec_p0.reg_wr     = 1'b1;
            end
            OPC_STORE: begin
                dec_p0.ext_op   = EXT_S;
                dec_p0.alu_src2 = 2'b01;
                dec_p0.mem_wr   = 1'b1;
                dec_p0.mem_op   = f3;
            end
            OPC_OPIMM, OPC_OPIMMW: begin
                dec_p0.ext_op   = EXT_I;
                dec_p0.alu_src2 = 2'b01;
                dec_p0.reg_wr   = 1'b1;
                dec_p0.is_word  = (opc == OPC_OPIMMW);
                dec_p0.alu_ctr  = alu_of(f3, (f3 == 3'b101) && instr[30]);
                // shamt[5] only exists on RV64
                if (XLEN == 32 && (f3 == 3'b001 || f3 == 3'b101) && instr[25])
                    dec_p0.illegal = 1'b1;
            end
            OPC_OP, OPC_OPW: begin
                dec_p0.reg_wr  = 1'b1;
                dec_p0.is_word = (opc == OPC_OPW);
                dec_p0.alu_ctr = alu_of(f3, instr[30] && (f3 == 3'b000 || f3 == 3'b101));
                if (f7 != 7'b0000000 && f7 != 7'b0100000)
                    dec_p0.illegal = 1'b1;
            end
            OPC_SYSTEM: dec_p0.ebreak = (instr == 32'h0010_0073);
            OPC_FENCE:  ;
            default:    dec_p0.illegal = 1'b1;
        endcase
        if (XLEN == 32 && (opc == OPC_OPIMMW || opc == OPC_OPW))
            dec_p0.illegal = 1'b1;
        if (dec_p0.illegal) begin
            dec_p0.reg_wr = 1'b0;
            dec_p0.mem_wr = 1'b0;
            dec_p0.branch = 3'b000;
        end
        case (dec_p0.ext_op)
            EXT_I:   imm_w = {{20{instr[31]}}, instr[31:20]};
            EXT_U:   imm_w = {instr[31:12], 12'h000};
            EXT_S:   imm_w = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            EXT_B:   imm_w = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            EXT_J:   imm_w = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_w = '0;
        endcase
        dec_p0.imm = XLEN'(imm_w);
    end

    // ---- stage boundary: decoded bundle enters the 2-entry FIFO (buf0 is head) ----
    logic [1:0] count;
    logic       halted_q;
    logic       push, pop;
    dec_t       buf0_p1, buf1_p1, head_p1;

    assign in_ready  = (count != 2'd2) && !halted_q;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            if (flush)
                count <= 2'd0;
            else
                count <= count + 2'(push) - 2'(pop);
            if (push && dec_p0.ebreak)
                halted_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            buf0_p1 <= (count == 2'd2) ? buf1_p1 : dec_p0;
            if (push)
                buf1_p1 <= dec_p0;
        end else if (push) begin
            if (count == 2'd0)
                buf0_p1 <= dec_p0;
            else
                buf1_p1 <= dec_p0;
        end
    end

    // Empty buffer presents the idle bundle, which is also the reset view
    always_comb begin
        head_p1 = buf0_p1;
        if (!out_valid) begin
            head_p1        = '0;
            head_p1.ext_op = EXT_NONE;
            head_p1.mem_op = 3'b111;
        end
    end

    assign rs1        = head_p1.rs1;
    assign rs2        = head_p1.rs2;
    assign rd         = head_p1.rd;
    assign imm        = head_p1.imm;
    assign ext_op     = head_p1.ext_op;
    assign reg_wr     = head_p1.reg_wr;
    assign branch     = head_p1.branch;
    assign mem_to_reg = head_p1.mem_to_reg;
    assign mem_wr     = head_p1.mem_wr;
    assign mem_op     = head_p1.mem_op;
    assign alu_src1   = head_p1.alu_src1;
    assign alu_src2   = head_p1.alu_src2;
    assign alu_ctr    = head_p1.alu_ctr;
    assign is_word    = head_p1.is_word;
    assign illegal    = head_p1.illegal;
    assign ebreak     = head_p1.ebreak;
    assign halted     = halted_q;

    a_depth: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'(DEPTH));

endmodule

// File: tb/tb_ysyx_22050854_idu_stage.sv
// Bench for the IDU stage: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literals on XLEN=64 and XLEN=32 instances.
module tb_ysyx_22050854_idu_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // XLEN=64 instance
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  ext_op, branch, mem_op;
    logic        reg_wr, mem_to_reg, mem_wr, alu_src1, is_word, illegal, ebreak, halted;
    logic [1:0]  alu_src2;
    logic [3:0]  alu_ctr;

    // XLEN=32 instance
    logic        in_valid32, in_ready32, flush32, out_valid32, out_ready32;
    logic [31:0] in_instr32;
    logic [4:0]  rs1_32, rs2_32, rd_32;
    logic [31:0] imm32;
    logic [2:0]  ext_op32, branch32, mem_op32;
    logic        reg_wr32, mem_to_reg32, mem_wr32, alu_src1_32, is_word32, illegal32, ebreak32, halted32;
    logic [1:0]  alu_src2_32;
    logic [3:0]  alu_ctr32;

    ysyx_22050854_idu_stage #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .ext_op(ext_op), .reg_wr(reg_wr), .branch(branch), .mem_to_reg(mem_to_reg),
        .mem_wr(mem_wr), .mem_op(mem_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
        .is_word(is_word), .illegal(illegal), .ebreak(ebreak), .halted(halted));

    ysyx_22050854_idu_stage #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32),
        .flush(flush32), .out_valid(out_valid32), .out_ready(out_ready32), .rs1(rs1_32), .rs2(rs2_32),
        .rd(rd_32), .imm(imm32), .ext_op(ext_op32), .reg_wr(reg_wr32), .branch(branch32),
        .mem_to_reg(mem_to_reg32), .mem_wr(mem_wr32), .mem_op(mem_op32), .alu_src1(alu_src1_32),
        .alu_src2(alu_src2_32), .alu_ctr(alu_ctr32), .is_word(is_word32), .illegal(illegal32),
        .ebreak(ebreak32), .halted(halted32));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm;
        logic [2:0]  ext_op;
        logic        reg_wr;
        logic [2:0]  branch;
        logic        mem_to_reg, mem_wr;
        logic [2:0]  mem_op;
        logic        alu_src1;
        logic [1:0]  alu_src2;
        logic [3:0]  alu_ctr;
        logic        is_word, illegal, ebreak;
    } bun_t;

    // operation name -> alu_ctr code
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'b1000 : 4'b0000;  // add / sub
            3'd1: return 4'b0001;                  // sll
            3'd2: return 4'b0010;                  // slt
            3'd3: return 4'b1010;                  // sltu
            3'd4: return 4'b0100;                  // xor
            3'd5: return alt ? 4'b1101 : 4'b0101;  // sra / srl
            3'd6: return 4'b0110;                  // or
            default: return 4'b0111;               // and
        endcase
    endfunction

    function automatic bun_t mdl(input logic [31:0] i);
        bun_t b;
        logic [2:0] f3;
        f3 = i[14:12];
        b = '0;
        b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7];
        b.ext_op = 3'b111; b.mem_op = 3'b111;
        case (i[6:0])
            7'h37: begin b.ext_op = 3'b001; b.imm = 64'(longint'($signed({i[31:12], 12'h0})));
                   b.alu_ctr = 4'b0011; b.alu_src2 = 2'b01; b.reg_wr = 1; end
            7'h17: begin b.ext_op = 3'b001; b.imm = 64'(longint'($signed({i[31:12], 12'h0})));
                   b.alu_src1 = 1; b.alu_src2 = 2'b01; b.reg_wr = 1; end
            7'h6f: begin b.ext_op = 3'b100;
                   b.imm = 64'(longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})));
                   b.alu_src1 = 1; b.alu_src2 = 2'b10; b.reg_wr = 1; b.branch = 3'b001; end
            7'h67: begin b.ext_op = 3'b000; b.imm = 64'(longint'($signed(i[31:20])));
                   b.alu_src1 = 1; b.alu_src2 = 2'b10; b.reg_wr = 1; b.branch = 3'b010; end
            7'h63: begin b.ext_op = 3'b011;
                   b.imm = 64'(longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})));
                   b.alu_ctr = (f3 == 3'd6 || f3 == 3'd7) ? 4'b1010 : 4'b0010;
                   case (f3)
                       3'd0: b.branch = 3'b100;
                       3'd1: b.branch = 3'b101;
                       3'd4, 3'd6: b.branch = 3'b110;
                       3'd5, 3'd7: b.branch = 3'b111;
                       default: b.branch = 3'b000;
                   endcase end
            7'h03: begin b.ext_op = 3'b000; b.imm = 64'(longint'($signed(i[31:20])));
                   b.alu_src2 = 2'b01; b.mem_to_reg = 1; b.mem_op = f3; b.reg_wr = 1; end
            7'h23: begin b.ext_op = 3'b010; b.imm = 64'(longint'($signed({i[31:25], i[11:7]})));
                   b.alu_src2 = 2'b01; b.mem_wr = 1; b.mem_op = f3; end
            7'h13, 7'h1b: begin b.ext_op = 3'b000; b.imm = 64'(longint'($signed(i[31:20])));
                   b.alu_src2 = 2'b01; b.reg_wr = 1; b.is_word = (i[6:0] == 7'h1b);
                   b.alu_ctr = alu_code(f3, (f3 == 3'd5) && i[30]); end
            7'h33, 7'h3b: begin b.reg_wr = 1; b.is_word = (i[6:0] == 7'h3b);
                   b.alu_ctr = alu_code(f3, i[30]);
                   b.illegal = !(i[31:25] == 7'h00 || i[31:25] == 7'h20); end
            7'h73: b.ebreak = (i == 32'h0010_0073);
            7'h0f: ;
            default: b.illegal = 1;
        endcase
        if (b.illegal) begin b.reg_wr = 0; b.mem_wr = 0; b.branch = 3'b000; end
        return b;
    endfunction

    bun_t q[$];
    bit   mhalt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            mhalt <= 1'b0;
        end else begin
            bit take;
            take = in_valid && (q.size() < 2) && !mhalt && !flush;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (take) begin
                    q.push_back(mdl(in_instr));
                    if (in_instr == 32'h0010_0073) mhalt <= 1'b1;
                end
            end
        end
    end

    // every-cycle compare on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            bun_t act;
            act = '{rs1, rs2, rd, imm, ext_op, reg_wr, branch, mem_to_reg, mem_wr, mem_op,
                    alu_src1, alu_src2, alu_ctr, is_word, illegal, ebreak};
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !mhalt));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("halted", 64'(halted), 64'(mhalt));
            if (q.size() != 0) begin
                nvec++;
                if (act !== q[0]) begin
                    nerr++;
                    $display("FAIL head_bundle: got %h want %h", act, q[0]);
                end
            end
        end
    end

    // offer one instruction from a falling edge until accepted (bounded)
    task automatic send(input logic [31:0] w);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_instr = w;
        for (int n = 0; n < 20 && !acc; n++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_instr = 'x;
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send32(input logic [31:0] w);
        in_valid32 = 1'b1;
        in_instr32 = w;
        @(posedge clk);
        @(negedge clk);
        in_valid32 = 1'b0;
        in_instr32 = 'x;
    endtask

    logic [31:0] tbl [16] = '{32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000080E7,
                              32'h00209463, 32'h0020C463, 32'h0020E463, 32'h0020F463,
                              32'h0040A183, 32'h00208023, 32'h0020B133, 32'h00209133,
                              32'h0050D093, 32'h402080BB, 32'h0FF0000F, 32'h00000073};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 'x; flush = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; in_instr32 = 'x; flush32 = 1'b0; out_ready32 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ext_op", 64'(ext_op), 64'd7);
        chk("rst_mem_op", 64'(mem_op), 64'd7);
        chk("rst_imm", imm, 64'd0);
        chk("rst_reg_wr", 64'(reg_wr), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h00500093);  // addi x1,x0,5
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(rd), 64'd1);
        chk("addi_rs1", 64'(rs1), 64'd0);
        chk("addi_imm", imm, 64'd5);
        chk("addi_ext", 64'(ext_op), 64'd0);
        chk("addi_ctr", 64'(alu_ctr), 64'd0);
        chk("addi_src2", 64'(alu_src2), 64'd1);
        chk("addi_regwr", 64'(reg_wr), 64'd1);
        chk("addi_illegal", 64'(illegal), 64'd0);

        send(32'h0020A423);  // sw x2,8(x1)
        chk("sw_memwr", 64'(mem_wr), 64'd1);
        chk("sw_memop", 64'(mem_op), 64'd2);
        chk("sw_imm", imm, 64'd8);
        chk("sw_ext", 64'(ext_op), 64'd2);
        chk("sw_regwr", 64'(reg_wr), 64'd0);
        chk("sw_rs1", 64'(rs1), 64'd1);
        chk("sw_rs2", 64'(rs2), 64'd2);

        send(32'hFFDFF0EF);  // jal x1,-4
        chk("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_branch", 64'(branch), 64'd1);
        send(32'h800000B7);  // lui x1,0x80000
        chk("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
        send(32'h40208133);  // sub
        chk("sub_ctr", 64'(alu_ctr), 64'b1000);
        send(32'h4050D093);  // srai x1,x1,5
        chk("srai_ctr", 64'(alu_ctr), 64'b1101);
        send(32'h4020D133);  // sra
        chk("sra_ctr", 64'(alu_ctr), 64'b1101);
        send(32'h00208463);  // beq x1,x2,8
        chk("beq_branch", 64'(branch), 64'b100);
        chk("beq_imm", imm, 64'd8);
        send(32'h02208133);  // mul: not in base ISA
        chk("mul_illegal", 64'(illegal), 64'd1);
        chk("mul_regwr", 64'(reg_wr), 64'd0);
        send(32'h0000007F);  // unknown opcode
        chk("unk_illegal", 64'(illegal), 64'd1);
        send(32'hFFC0B183);  // ld x3,-4(x1)
        chk("ld_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("ld_m2r", 64'(mem_to_reg), 64'd1);
        send(32'h0010009B);  // addiw x1,x0,1
        chk("addiw64_word", 64'(is_word), 64'd1);
        chk("addiw64_imm", imm, 64'd1);
        chk("addiw64_regwr", 64'(reg_wr), 64'd1);
        chk("addiw64_illegal", 64'(illegal), 64'd0);
        send(32'h02009093);  // slli x1,x1,32 legal on RV64
        chk("slli32_64_illegal", 64'(illegal), 64'd0);
        foreach (tbl[k]) send(tbl[k]);
        repeat (2) @(negedge clk);

        // back-pressure: two fit, the third waits, then all drain in order
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        chk("bp_full_ready", 64'(in_ready), 64'd0);
        chk("bp_head_rd", 64'(rd), 64'd1);
        fork
            send(32'h00300193);
            begin
                repeat (2) @(negedge clk);
                chk("bp_stall_ready", 64'(in_ready), 64'd0);
                chk("bp_stall_rd", 64'(rd), 64'd1);
                out_ready = 1'b1;
            end
        join
        chk("bp_third_rd", 64'(rd), 64'd3);
        chk("bp_third_valid", 64'(out_valid), 64'd1);
        @(negedge clk);

        // flush with a simultaneous offer
        out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200113);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300193;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; in_instr = 'x;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // ebreak halts intake; entry still drains
        out_ready = 1'b0;
        send(32'h00100073);
        in_valid = 1'b1; in_instr = 32'h00500093;
        repeat (3) @(negedge clk);
        chk("eb_halted", 64'(halted), 64'd1);
        chk("eb_ready", 64'(in_ready), 64'd0);
        chk("eb_head", 64'(ebreak), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("eb_drained", 64'(out_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; in_instr = 'x;
        chk("eb_flush_keeps_halt", 64'(halted), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("eb_reset_halt", 64'(halted), 64'd0);
        @(negedge clk);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h00500093);
        send(32'h0020A423);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // XLEN=32 instance
        send32(32'h0010009B);
        chk("x32_addiw_illegal", 64'(illegal32), 64'd1);
        chk("x32_addiw_regwr", 64'(reg_wr32), 64'd0);
        send32(32'h02009093);
        chk("x32_slli32_illegal", 64'(illegal32), 64'd1);
        send32(32'h00500093);
        chk("x32_addi_illegal", 64'(illegal32), 64'd0);
        chk("x32_addi_imm", 64'(imm32), 64'd5);
        send32(32'h800000B7);
        chk("x32_lui_imm", 64'(imm32), 64'h8000_0000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22050854_idu_stage.md
Name: ysyx_22050854_idu_stage

Overview:
Registered, handshaked instruction-decode stage for the NPC pipeline, sitting between IFU and EXU. It decodes RV32I/RV64I base instructions (XLEN-parametrised) into the team's standard control bundle and generates the sign-extended immediate. It also flags illegal encodings and ebreak. A 2-entry skid buffer lets it absorb downstream back-pressure without combinational ready paths.

Parameters:
XLEN, 64, datapath width; 32 or 64 only; width of imm, selects legality of W-ops
DEPTH, 2, skid buffer entries; fixed at 2, kept as a parameter for assertions

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IFU presents instr
in_ready  out  1  stage accepts instr this cycle
in_instr  in  32  raw instruction
flush  in  1  drop all buffered entries (redirect)
out_valid  out  1  head entry valid
out_ready  in  1  EXU consumes head
rs1, rs2, rd  out  5 each  register fields
imm  out  XLEN  sign-extended immediate per ext_op
ext_op  out  3  000 I, 001 U, 010 S, 011 B, 100 J, 111 none
reg_wr  out  1  write rd
branch  out  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu
mem_to_reg  out  1  1 = writeback from memory
mem_wr  out  1  store
mem_op  out  3  funct3 for load/store, 111 otherwise
alu_src1  out  1  0 rs1, 1 pc
alu_src2  out  2  00 rs2, 01 imm, 10 const 4
alu_ctr  out  4  0000 add, 1000 sub, 0001 sll, 0010 slt, 1010 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 0011 copy-B
is_word  out  1  OP-IMM-32/OP-32 (32-bit result, sext)
illegal  out  1  undecodable instruction
ebreak  out  1  head is ebreak (0x00100073)
halted  out  1  sticky: ebreak accepted

Behaviour:
- Reset (async on rst_n low): both entries invalid, count=0, halted=0; out_valid=0, all decoded outputs 0 except mem_op=111, ext_op=111. Deassertion is synchronous to clk.
- Decode is combinational on in_instr; the decoded bundle is written into the buffer on in handshake (in_valid & in_ready). Outputs always reflect the head entry. When the buffer is empty, latency is 1 cycle (accept at edge N -> out_valid high after edge N).
- in_ready = (count < 2) & ~halted; registered, with no combinational path from out_ready.
- Same-cycle in-handshake and out-handshake: count unchanged; the new entry goes behind the current second entry. Order is strictly FIFO.
- out_valid must not drop and the head must not change while out_valid & ~out_ready (stable-until-consumed).
- flush: at next edge count=0 and out_valid=0. An instruction offered in the same cycle is discarded even if in_ready=1. flush does not clear halted.
- ebreak: on accept, halted=1 at the same edge. The ebreak entry still drains normally with ebreak=1. No further input is accepted until reset.
- illegal=1 for:
  - unknown opcode;
  - funct7 not 0000000/0100000 on OP/OP-32;
  - OP-IMM-32/OP-32 when XLEN=32;
  - shift shamt[5]=1 when XLEN=32.
- Illegal entries force reg_wr=0, mem_wr=0, branch=000, and still handshake normally.
- imm sign-extended from its top instruction bit to XLEN. U-type places bits[31:12] at imm[31:12] and sign-extends. B/J immediates have bit0=0.
- Decode rules:
  - lui: alu_ctr=copy, alu_src2=01.
  - auipc: alu_src1=1, alu_src2=01, add.
  - jal/jalr: alu_src1=1, alu_src2=10, add, reg_wr=1.
  - branches: alu_src2=00, slt (beq/bne/blt/bge) or sltu (bltu/bgeu).
  - loads/stores: add, alu_src2=01.
  - loads: mem_to_reg=1.
  - stores: mem_wr=1, reg_wr=0.
  - srai/srli are distinguished by instr[30].
- Input X on in_instr while in_valid=0 must not propagate.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 -> one cycle later out_valid=1, rd=1, rs1=0, imm=5, ext_op=000, alu_ctr=0000, alu_src2=01, reg_wr=1, illegal=0.
- sw x2,8(x1) (0x0020A423) -> mem_wr=1, mem_op=010, imm=8, ext_op=010, reg_wr=0, rs1=1, rs2=2.
- Back-pressure: out_ready=0, offer 3 instrs -> first two accepted, in_ready=0 on third. Raise out_ready -> all three emerge in order; out_valid never glitches low between them.
- ebreak (0x00100073) followed by addi -> halted=1, in_ready=0 thereafter. ebreak drains with ebreak=1; addi is never accepted until rst_n pulse.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, offered instr dropped.
- XLEN=32: addiw x1,x0,1 (0x0010009B) -> illegal=1, reg_wr=0. With XLEN=64 the same instr -> is_word=1, imm=1, reg_wr=1. Async rst_n low mid-stream -> out_valid=0 immediately, without waiting for clk.
